div_arbiter: RTL

DIV_ARBITER -- requirements
Module: div_arbiter

---
 rtl/div_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/div_arbiter.sv
// Two-requester round-robin front end for a single shared divider.
// Latches the winner's operands, strobes the divider, then returns result flags with a watchdog fallback.
module div_arbiter #(
    parameter int DW  = 10,
    parameter int TMO = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic [DW-1:0] a0,
    input  logic [DW-1:0] b0,
    input  logic [DW-1:0] a1,
    input  logic [DW-1:0] b1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] res_q,
    output logic          res_dvz,
    output logic          res_ovf,
    output logic          res_tmo,
    output logic          arb_busy,
    output logic          div_start,
    output logic [DW-1:0] div_a,
    output logic [DW-1:0] div_b,
    input  logic [DW-1:0] div_q,
    input  logic          div_valid,
    input  logic          div_dvz,
    input  logic          div_ovf
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Counter value seen during the last permitted WAIT cycle (counter starts at 0 in WAIT cycle 1).
    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_owner;
    logic        r_ptr;
    logic [7:0]  r_cnt;
    logic        w_any_req;
    logic        w_winner;
    logic        w_cmpl;
    logic        w_tmo;

    assign w_any_req = req0 | req1;
    // On contention the requester not served last wins; a lone request always wins.
    assign w_winner  = (req0 & req1) ? ~r_ptr : req1;
    assign w_cmpl    = div_valid | div_dvz | div_ovf;
    assign w_tmo     = (r_cnt == TMO_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_next = S_ISSUE;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: begin
                if (w_cmpl || w_tmo) begin
                    w_next = S_RESP;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode from state and the registered owner only.
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        done0     = 1'b0;
        done1     = 1'b0;
        div_start = 1'b0;
        arb_busy  = (r_state != S_IDLE);
        case (r_state)
            S_ISSUE: begin
                div_start = 1'b1;
                gnt0      = ~r_owner;
                gnt1      = r_owner;
            end
            S_RESP: begin
                done0 = ~r_owner;
                done1 = r_owner;
            end
            default: begin
                div_start = 1'b0;
            end
        endcase
    end

    // Datapath: operand latch, owner/pointer, watchdog counter and result capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner <= 1'b0;
            r_ptr   <= 1'b1;
            r_cnt   <= 8'd0;
            div_a   <= {DW{1'b0}};
            div_b   <= {DW{1'b0}};
            res_q   <= {DW{1'b0}};
            res_dvz <= 1'b0;
            res_ovf <= 1'b0;
            res_tmo <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_winner;
                        div_a   <= w_winner ? a1 : a0;
                        div_b   <= w_winner ? b1 : b0;
                    end
                end
                S_ISSUE: begin
                    r_cnt <= 8'd0;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 8'd1;
                    // A completion in the timeout cycle takes precedence over the watchdog.
                    if (w_cmpl) begin
                        res_q   <= div_q;
                        res_dvz <= div_dvz;
                        res_ovf <= div_ovf;
                        res_tmo <= 1'b0;
                    end else if (w_tmo) begin
                        res_dvz <= 1'b0;
                        res_ovf <= 1'b0;
                        res_tmo <= 1'b1;
                    end
                end
                S_RESP: begin
                    r_ptr <= r_owner;
                end
                default: begin
                    r_ptr <= r_ptr;
                end
            endcase
        end
    end

endmodule
